ew_threat_controller: RTL and testbench
=======================================

// Module: ew_threat_controller
// PURPOSE
//  Threat-response sequencer that owns the EW FSM state register (3-bit fsm_state).
//  Takes the jam and spoof detector flags plus the entropy analyser result, and decides whether to engage countermeasures.
//  Drives a req/ack handshake to the countermeasure unit, then times the hold and recovery windows.
//  fsm_state goes to the system and to the EW FSM assertion checker.
// PARAMETERS
//  FSM_BITS        3    state encoding width (fixed encoding below)
//  ENT_WIDTH       8    entropy_value width
//  ENT_THRESH      200  entropy >= this confirms jamming
//  ENT_TIMEOUT     32   cycles to wait for entropy_valid before fail-safe engage
//  CM_CYCLES       16   countermeasure hold cycles after cm_ack
//  RECOVERY_CYCLES 8    cycles spent in RECOVERY
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          asynchronous, active-low reset
//  jam_detect     in   1          jamming detector flag
//  spoof_detect   in   1          spoofing detector flag
//  entropy_valid  in   1          entropy_value qualifier (single-cycle pulse)
//  entropy_value  in   ENT_WIDTH  entropy measurement, unsigned
//  cm_ack         in   1          countermeasure unit accepts request
//  cm_req         out  1          countermeasure request, level, held until ack
//  cm_type        out  2          01 jam, 10 spoof, 11 both; 00 when cm_req=0
//  fsm_state      out  FSM_BITS   current state (registered)
//  threat_count   out  8          engagements since reset, saturates at 255
//  busy           out  1          1 when fsm_state is neither IDLE nor MONITOR
// BEHAVIOUR
//  Encoding: IDLE=0, MONITOR=1, JAMMED=2, SPOOF_DETECTED=3, ENTROPY_ANALYZED=4, COUNTER_MEASURE=5, RECOVERY=6. Code 7 is illegal.
//  Reset (rst_n=0, asynchronous): fsm_state=IDLE; all outputs, counters and latched flags = 0.
//  All outputs are registered. An input sampled at edge N affects outputs after edge N.
//  IDLE: always -> MONITOR on the next edge (lasts exactly 1 cycle).
//  MONITOR:
//    - jam_detect -> JAMMED, latching jam=1 and spoof=spoof_detect.
//    - else spoof_detect -> SPOOF_DETECTED, latching spoof=1.
//    - else stay in MONITOR.
//  JAMMED / SPOOF_DETECTED: 1 cycle, then -> ENTROPY_ANALYZED. Clears the timeout counter.
//    JAMMED never goes directly to COUNTER_MEASURE or RECOVERY.
//  ENTROPY_ANALYZED:
//    - entropy_valid and (entropy_value >= ENT_THRESH or spoof latched) -> COUNTER_MEASURE.
//    - entropy_valid otherwise -> MONITOR (false alarm). Latched flags clear; threat_count unchanged.
//    - No entropy_valid for ENT_TIMEOUT cycles -> COUNTER_MEASURE (fail safe).
//  COUNTER_MEASURE:
//    - On entry: threat_count += 1 (saturating); cm_req=1; cm_type = {spoof, jam}.
//    - cm_req stays high until cm_ack is sampled high, then drops on the following edge.
//    - cm_ack while cm_req=0 is ignored.
//    - The hold counter starts the cycle after the ack. After CM_CYCLES cycles -> RECOVERY.
//  RECOVERY: lasts RECOVERY_CYCLES cycles, then -> MONITOR; latched flags clear.
//    Detector flags are ignored during RECOVERY.
//  Illegal state 7: -> IDLE on the next edge; cm_req forced to 0.
//  Counter widths: $clog2(max(ENT_TIMEOUT, CM_CYCLES, RECOVERY_CYCLES) + 1).
//  Reset mid-operation drops cm_req immediately, with no handshake completion.
// CONFIGURATION
//  EW_CM_ABORT_EN defined: adds input cm_abort (1 bit).
//    cm_abort sampled high in COUNTER_MEASURE -> RECOVERY next edge; cm_req=0 and the hold counter clears.
//    cm_abort has priority over cm_ack in the same cycle. It is ignored in every other state.
//  EW_CM_ABORT_EN undefined: no cm_abort port; COUNTER_MEASURE exits only via the hold timeout.
// TESTING
//  T1: release rst_n -> fsm_state=0 for 1 cycle, then 1. busy=0, cm_req=0.
//  T2: jam_detect=1 (1 cycle), entropy_valid with value 230 two cycles later -> states 2,4,5; cm_req=1, cm_type=01.
//      cm_ack after 3 cycles -> 16 cycles in 5, 8 cycles in 6, then 1. threat_count=1.
//  T3: jam + spoof in the same cycle -> state 2, cm_type=11.
//      Spoof-only with entropy 50 -> engages. Jam-only with entropy 50 -> back to 1, threat_count unchanged.
//  T4: jam_detect, no entropy_valid -> exactly 32 cycles in state 4, then 5. Check count saturates at 255 after 256 engagements.
//  T5: rst_n low while in state 5 with cm_req=1 -> same cycle fsm_state=0, cm_req=0, threat_count=0.
//      Force state 7 (via force) -> state 0 next edge.
//  T6 (EW_CM_ABORT_EN): cm_abort and cm_ack together in state 5 -> state 6 next edge, cm_req=0.
//      cm_abort in state 1 has no effect.

Source files
------------

// File: rtl/ew_threat_controller.sv
// EW threat-response sequencer: detector flags -> entropy check -> countermeasure handshake -> hold -> recovery.
// Optional macro EW_CM_ABORT_EN adds a cm_abort input that cuts a countermeasure short.
package ew_threat_pkg;
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MONITOR  = 3'd1,
    ST_JAMMED   = 3'd2,
    ST_SPOOF    = 3'd3,
    ST_ENTROPY  = 3'd4,
    ST_CM       = 3'd5,
    ST_RECOVERY = 3'd6,
    ST_ILLEGAL  = 3'd7
  } ew_state_t;
endpackage

module ew_threat_controller
  import ew_threat_pkg::*;
#(
  parameter int FSM_BITS        = 3,
  parameter int ENT_WIDTH       = 8,
  parameter int ENT_THRESH      = 200,
  parameter int ENT_TIMEOUT     = 32,
  parameter int CM_CYCLES       = 16,
  parameter int RECOVERY_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 jam_detect,
  input  logic                 spoof_detect,
  input  logic                 entropy_valid,
  input  logic [ENT_WIDTH-1:0] entropy_value,
  input  logic                 cm_ack,
`ifdef EW_CM_ABORT_EN
  input  logic                 cm_abort,
`endif
  output logic                 cm_req,
  output logic [1:0]           cm_type,
  output logic [FSM_BITS-1:0]  fsm_state,
  output logic [7:0]           threat_count,
  output logic                 busy
);

  localparam int MAX_A   = (ENT_TIMEOUT > CM_CYCLES) ? ENT_TIMEOUT : CM_CYCLES;
  localparam int MAX_CYC = (MAX_A > RECOVERY_CYCLES) ? MAX_A : RECOVERY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]     ENT_LAST = CNT_W'(ENT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     CM_LAST  = CNT_W'(CM_CYCLES - 1);
  localparam logic [CNT_W-1:0]     REC_LAST = CNT_W'(RECOVERY_CYCLES - 1);
  localparam logic [ENT_WIDTH-1:0] THRESH   = ENT_WIDTH'(ENT_THRESH);

  ew_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             jam_l;
  logic             spoof_l;
  logic             abort;

`ifdef EW_CM_ABORT_EN
  assign abort = cm_abort;
`else
  assign abort = 1'b0;
`endif

  assign fsm_state = FSM_BITS'(state);

  // One counter is shared by the entropy timeout, the post-ack hold and the recovery window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      jam_l        <= 1'b0;
      spoof_l      <= 1'b0;
      cm_req       <= 1'b0;
      cm_type      <= 2'b00;
      threat_count <= 8'd0;
      busy         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_MONITOR;
          busy  <= 1'b0;
        end
        ST_MONITOR: begin
          if (jam_detect) begin
            state   <= ST_JAMMED;
            jam_l   <= 1'b1;
            spoof_l <= spoof_detect;
            busy    <= 1'b1;
          end else if (spoof_detect) begin
            state   <= ST_SPOOF;
            spoof_l <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_JAMMED, ST_SPOOF: begin
          state <= ST_ENTROPY;
          cnt   <= '0;
        end
        ST_ENTROPY: begin
          // A spoof finding engages regardless of entropy; a missing result engages as fail-safe.
          if (entropy_valid && !((entropy_value >= THRESH) || spoof_l)) begin
            state   <= ST_MONITOR;
            jam_l   <= 1'b0;
            spoof_l <= 1'b0;
            busy    <= 1'b0;
          end else if (entropy_valid || (cnt == ENT_LAST)) begin
            state   <= ST_CM;
            cnt     <= '0;
            cm_req  <= 1'b1;
            cm_type <= {spoof_l, jam_l};
            if (threat_count != 8'hFF) threat_count <= threat_count + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CM: begin
          if (abort) begin
            state   <= ST_RECOVERY;
            cnt     <= '0;
            cm_req  <= 1'b0;
            cm_type <= 2'b00;
          end else if (cm_req) begin
            if (cm_ack) begin
              cm_req  <= 1'b0;
              cm_type <= 2'b00;
              cnt     <= '0;
            end
          end else if (cnt == CM_LAST) begin
            state <= ST_RECOVERY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RECOVERY: begin
          if (cnt == REC_LAST) begin
            state   <= ST_MONITOR;
            cnt     <= '0;
            jam_l   <= 1'b0;
            spoof_l <= 1'b0;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          cm_req  <= 1'b0;
          cm_type <= 2'b00;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ew_threat_controller.sv
// Self-checking bench for ew_threat_controller; engagements are scoreboarded by cm_type and threat_count.
// The cm_abort scenario is built only when EW_CM_ABORT_EN is defined.
module tb_ew_threat_controller;
  import ew_threat_pkg::*;

  typedef struct packed {
    logic [1:0] typ;
    logic [7:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       jam_detect;
  logic       spoof_detect;
  logic       entropy_valid;
  logic [7:0] entropy_value;
  logic       cm_ack;
`ifdef EW_CM_ABORT_EN
  logic       cm_abort;
`endif
  logic       cm_req;
  logic [1:0] cm_type;
  logic [2:0] fsm_state;
  logic [7:0] threat_count;
  logic       busy;

  exp_t       sb[$];
  logic [7:0] exp_count;
  int         tests_run;
  int         tests_failed;

  ew_threat_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .jam_detect    (jam_detect),
    .spoof_detect  (spoof_detect),
    .entropy_valid (entropy_valid),
    .entropy_value (entropy_value),
    .cm_ack        (cm_ack),
`ifdef EW_CM_ABORT_EN
    .cm_abort      (cm_abort),
`endif
    .cm_req        (cm_req),
    .cm_type       (cm_type),
    .fsm_state     (fsm_state),
    .threat_count  (threat_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one detector event from MONITOR and reports how many cycles ENTROPY_ANALYZED lasted.
  task automatic run_threat(input bit jam, input bit spoof, input bit give,
                            input logic [7:0] val, output int n4);
    bit   engage;
    exp_t e;
    engage = spoof || !give || (val >= 8'd200);
    jam_detect   = jam;
    spoof_detect = spoof;
    if (engage) begin
      if (exp_count != 8'hFF) exp_count = exp_count + 8'd1;
      e.typ = {spoof, jam};
      e.cnt = exp_count;
      sb.push_back(e);
    end
    @(negedge clk);
    jam_detect   = 1'b0;
    spoof_detect = 1'b0;
    tests_run++;
    if (fsm_state !== (jam ? 3'd2 : 3'd3)) begin
      tests_failed++;
      $display("[TB] FAIL detect_state: got %0d expected %0d", fsm_state, jam ? 2 : 3);
    end
    @(negedge clk);
    if (give) begin
      entropy_valid = 1'b1;
      entropy_value = val;
      @(negedge clk);
      entropy_valid = 1'b0;
    end
    n4 = 0;
    while (fsm_state == 3'd4 && n4 < 64) begin
      @(negedge clk);
      n4++;
    end
    tests_run++;
    if (fsm_state == 3'd5 && cm_req === 1'b1) begin
      if (sb.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_engage: got type %0d count %0d expected no engagement",
                 cm_type, threat_count);
      end else begin
        e = sb.pop_front();
        if (cm_type !== e.typ || threat_count !== e.cnt) begin
          tests_failed++;
          $display("[TB] FAIL engage: got type %0d count %0d expected type %0d count %0d",
                   cm_type, threat_count, e.typ, e.cnt);
        end
      end
    end else if (fsm_state == 3'd1) begin
      if (sb.size() != 0) begin
        tests_failed++;
        $display("[TB] FAIL missed_engage: got state 1 expected state 5 with cm_req");
        sb.delete();
      end
    end else begin
      tests_failed++;
      $display("[TB] FAIL threat_outcome: got state %0d cm_req %0b expected state 5 or 1",
               fsm_state, cm_req);
    end
  endtask

  task automatic finish_cm(input int ack_delay);
    int n;
    repeat (ack_delay) @(negedge clk);
    cm_ack = 1'b1;
    @(negedge clk);
    cm_ack = 1'b0;
    n = 0;
    while (fsm_state != 3'd1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (fsm_state !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL return_monitor: got state %0d expected 1", fsm_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (fsm_state !== 3'd0 || cm_req !== 1'b0 || busy !== 1'b0 || threat_count !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL in_reset: got state %0d req %0b busy %0b count %0d expected 0 0 0 0",
               fsm_state, cm_req, busy, threat_count);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (fsm_state !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_release: got %0d expected 0", fsm_state);
    end
    @(negedge clk);
    tests_run++;
    if (fsm_state !== 3'd1 || busy !== 1'b0 || cm_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL monitor_after_idle: got state %0d busy %0b req %0b expected 1 0 0",
               fsm_state, busy, cm_req);
    end
  endtask

  task automatic test_jam_engage();
    exp_t e;
    int   n;
    jam_detect = 1'b1;
    exp_count  = exp_count + 8'd1;
    e.typ = 2'b01;
    e.cnt = exp_count;
    sb.push_back(e);
    @(negedge clk);
    jam_detect = 1'b0;
    tests_run++;
    if (fsm_state !== 3'd2 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL t2_jammed: got state %0d busy %0b expected 2 1", fsm_state, busy);
    end
    @(negedge clk);
    tests_run++;
    if (fsm_state !== 3'd4) begin
      tests_failed++;
      $display("[TB] FAIL t2_entropy_state: got %0d expected 4", fsm_state);
    end
    entropy_valid = 1'b1;
    entropy_value = 8'd230;
    @(negedge clk);
    entropy_valid = 1'b0;
    tests_run++;
    e = sb.pop_front();
    if (fsm_state !== 3'd5 || cm_req !== 1'b1 || cm_type !== e.typ || threat_count !== e.cnt) begin
      tests_failed++;
      $display("[TB] FAIL t2_engage: got state %0d req %0b type %0d count %0d expected 5 1 %0d %0d",
               fsm_state, cm_req, cm_type, threat_count, e.typ, e.cnt);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (cm_req !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL t2_req_held: got %0b expected 1", cm_req);
    end
    cm_ack = 1'b1;
    @(negedge clk);
    cm_ack = 1'b0;
    tests_run++;
    if (cm_req !== 1'b0 || cm_type !== 2'b00 || fsm_state !== 3'd5) begin
      tests_failed++;
      $display("[TB] FAIL t2_ack: got req %0b type %0d state %0d expected 0 0 5",
               cm_req, cm_type, fsm_state);
    end
    n = 0;
    while (fsm_state == 3'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n != 16) begin
      tests_failed++;
      $display("[TB] FAIL t2_hold_cycles: got %0d expected 16", n);
    end
    n = 0;
    while (fsm_state == 3'd6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n != 8) begin
      tests_failed++;
      $display("[TB] FAIL t2_recovery_cycles: got %0d expected 8", n);
    end
    tests_run++;
    if (fsm_state !== 3'd1 || busy !== 1'b0 || threat_count !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL t2_done: got state %0d busy %0b count %0d expected 1 0 1",
               fsm_state, busy, threat_count);
    end
  endtask

  task automatic test_mixed_threats();
    int n;
    run_threat(1'b1, 1'b1, 1'b1, 8'd50, n);
    finish_cm(0);
    run_threat(1'b0, 1'b1, 1'b1, 8'd50, n);
    finish_cm(1);
    run_threat(1'b1, 1'b0, 1'b1, 8'd50, n);
    tests_run++;
    if (threat_count !== exp_count || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL false_alarm: got count %0d busy %0b expected %0d 0",
               threat_count, busy, exp_count);
    end
  endtask

  task automatic test_timeout();
    int n;
    run_threat(1'b1, 1'b0, 1'b0, 8'd0, n);
    tests_run++;
    if (n != 32) begin
      tests_failed++;
      $display("[TB] FAIL entropy_timeout: got %0d cycles expected 32", n);
    end
    finish_cm(0);
  endtask

  task automatic test_saturation();
    int n;
    for (int i = 0; i < 256; i++) begin
      run_threat(1'b1, 1'b0, 1'b1, 8'd230, n);
      finish_cm(0);
    end
    tests_run++;
    if (threat_count !== 8'd255) begin
      tests_failed++;
      $display("[TB] FAIL saturation: got %0d expected 255", threat_count);
    end
  endtask

  task automatic test_reset_and_illegal();
    int n;
    run_threat(1'b1, 1'b0, 1'b1, 8'd230, n);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (fsm_state !== 3'd0 || cm_req !== 1'b0 || threat_count !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: got state %0d req %0b count %0d expected 0 0 0",
               fsm_state, cm_req, threat_count);
    end
    exp_count = 8'd0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    force dut.state = ST_ILLEGAL;
    #1;
    release dut.state;
    @(negedge clk);
    tests_run++;
    if (fsm_state !== 3'd0 || cm_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL illegal_recover: got state %0d req %0b expected 0 0", fsm_state, cm_req);
    end
    @(negedge clk);
    tests_run++;
    if (fsm_state !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL illegal_to_monitor: got %0d expected 1", fsm_state);
    end
  endtask

`ifdef EW_CM_ABORT_EN
  task automatic test_abort();
    int n;
    run_threat(1'b1, 1'b0, 1'b1, 8'd230, n);
    cm_abort = 1'b1;
    cm_ack   = 1'b1;
    @(negedge clk);
    cm_abort = 1'b0;
    cm_ack   = 1'b0;
    tests_run++;
    if (fsm_state !== 3'd6 || cm_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort: got state %0d req %0b expected 6 0", fsm_state, cm_req);
    end
    n = 0;
    while (fsm_state != 3'd1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    cm_abort = 1'b1;
    @(negedge clk);
    cm_abort = 1'b0;
    tests_run++;
    if (fsm_state !== 3'd1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_in_monitor: got state %0d busy %0b expected 1 0", fsm_state, busy);
    end
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    jam_detect    = 1'b0;
    spoof_detect  = 1'b0;
    entropy_valid = 1'b0;
    entropy_value = 8'd0;
    cm_ack        = 1'b0;
`ifdef EW_CM_ABORT_EN
    cm_abort      = 1'b0;
`endif
    exp_count     = 8'd0;
    tests_run     = 0;
    tests_failed  = 0;
    test_reset();
    test_jam_engage();
    test_mixed_threats();
    test_timeout();
    test_saturation();
    test_reset_and_illegal();
`ifdef EW_CM_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
